dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//  Parametrised vector dot-product unit. Holds a length register and two vectors (A, B) of
//  WORD_W-bit unsigned elements in a word-addressed store. A RUN command computes
//  sum(A[i]*B[i]) over LANES elements per cycle into an ACC_W-bit result register. The
//  result is either cleared or accumulated, has a sticky overflow flag, and is read back
//  word by word. Sits behind the chip's pin-level command decoder.
// PARAMETERS
//  WORD_W   4   element/word width in bits
//  MAX_LEN  16  max vector length; must be a multiple of LANES
//  LANES    4   multiply lanes evaluated per MAC cycle
//  ACC_W    16  result width; must be a multiple of WORD_W; RES_WORDS = ACC_W/WORD_W
//  ADDR_W   6   command address width; requires 2^ADDR_W >= 2*MAX_LEN+1+RES_WORDS
// PORTS
//  clk        in   1       clock; all logic is on the rising edge
//  rst        in   1       synchronous reset, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready; equals ~busy
//  cmd_op     in   2       0=READ 1=WRITE 2=RUN 3=CLEAR
//  cmd_addr   in   ADDR_W  word address (READ/WRITE)
//  cmd_wdata  in   WORD_W  write data (WRITE)
//  run_accum  in   1       RUN only: 1=start from current result, 0=start from 0
//  rd_data    out  WORD_W  registered read data
//  rd_valid   out  1       1-cycle pulse, one cycle after an accepted READ
//  busy       out  1       MAC in progress
//  done       out  1       1-cycle pulse when the result is final
//  overflow   out  1       sticky: result exceeded 2^ACC_W-1 since the last CLEAR or reset
// BEHAVIOUR
//  Map: 0=LEN; 1..MAX_LEN=A[0..]; MAX_LEN+1..2*MAX_LEN=B[0..];
//   2*MAX_LEN+1..+RES_WORDS=result, least-significant word first, read-only.
//  Effective length L = (LEN==0) ? MAX_LEN : min(LEN, MAX_LEN). N = ceil(L/LANES).
//  Reset: busy=0, done=0, rd_valid=0, rd_data=0, overflow=0, result=0, LEN=0, FSM=IDLE.
//   A/B storage is not reset.
//  FSM IDLE->MAC on an accepted RUN (cycle T). MAC covers cycles T+1..T+N, LANES elements
//   per cycle; lanes with index >= L contribute 0. IDLE in T+N+1: busy=0, done=1.
//  busy is high in T+1..T+N. cmd_ready is low during MAC, so no command is accepted then.
//  At T, acc <= run_accum ? result : 0. The result register is written at the end of T+N.
//   The result is unchanged during MAC.
//  Products are 2*WORD_W bits, zero-extended to ACC_W+1 for the sum. A carry out of ACC_W
//   on any step sets overflow.
//  READ: rd_data <= word at cmd_addr. Unmapped address -> 0. rd_valid=1 next cycle.
//  WRITE: writes LEN/A/B. Writes to result or unmapped addresses are ignored.
//  CLEAR: result <= 0 and overflow <= 0 in one cycle.
//  Reset mid-MAC: aborts next edge. No done pulse; result=0.
//  cmd_valid with cmd_ready low: the command is held off and accepted in the first cycle
//   cmd_ready=1.
// CONFIGURATION
//  DOT_PRODUCT_SATURATE_EN defined: when overflow occurs, acc clamps to all-ones and stays
//   there for the rest of the run. overflow is set as normal.
//  Undefined: acc wraps modulo 2^ACC_W; overflow is still set.
// TESTING
//  1. LEN=3, A=[1,2,3], B=[4,5,6], RUN accum=0 at T -> busy T+1, done at T+2;
//     result reads 0x0,0x2,0x0,0x0 (=32); overflow=0.
//  2. LEN=0, all A=B=15, RUN -> busy T+1..T+4, done T+5; result=3600 (0x0E10).
//  3. Repeat scenario 1 with accum=1 -> result 64. Then CLEAR -> result 0.
//  4. Bench ACC_W=8, scenario 2 data -> 3600 does not fit: overflow=1 with result 0x10
//     (macro undefined) or 0xFF (DOT_PRODUCT_SATURATE_EN).
//  5. WRITE/READ while busy: cmd_valid held, not accepted until the done cycle; a READ of
//     addr 5 returns A[4] with rd_valid 1 cycle later. A write to a result address is ignored.
//  6. Assert rst during MAC cycle 2 -> busy=0, result=0, no done pulse, LEN=0.
//     A/B are intact on readback.

Source files
------------

// File: rtl/dot_product_engine.sv
// dot_product_engine: LANES-wide MAC over a word-addressed LEN/A/B store.
// Build option: DOT_PRODUCT_SATURATE_EN clamps the accumulator on overflow.
module dot_product_engine #(
  parameter int WORD_W  = 4,
  parameter int MAX_LEN = 16,
  parameter int LANES   = 4,
  parameter int ACC_W   = 16,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_wdata,
  input  logic              run_accum,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int RES_WORDS = ACC_W / WORD_W;
  localparam int NCH       = MAX_LEN / LANES;
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW        = 2 * WORD_W;
  localparam int B_BASE    = MAX_LEN + 1;
  localparam int R_BASE    = 2 * MAX_LEN + 1;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

  state_t state;

  logic [WORD_W-1:0] a_mem [MAX_LEN];
  logic [WORD_W-1:0] b_mem [MAX_LEN];

  logic [WORD_W-1:0] len_q;
  logic [ACC_W-1:0]  result_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     last_ch;
  logic              step_ovf;

  int unsigned       eff_len;
  int unsigned       addr_i;
  int unsigned       idx;
  logic [PW-1:0]     prod;
  logic [ACC_W:0]    sum_t;
  logic [ACC_W-1:0]  run_s;

  logic              fire;
  logic              do_rd;
  logic              do_wr;
  logic              do_run;
  logic              do_clr;
  logic [WORD_W-1:0] rd_word;

  assign cmd_ready = ~busy;
  assign fire      = cmd_valid & cmd_ready;
  assign do_rd     = fire && (cmd_op == OP_READ);
  assign do_wr     = fire && (cmd_op == OP_WRITE);
  assign do_run    = fire && (cmd_op == OP_RUN);
  assign do_clr    = fire && (cmd_op == OP_CLEAR);
  assign addr_i    = 32'(cmd_addr);

  // Effective length (0 or oversize means full) and index of the last lane group
  always_comb begin
    eff_len = 32'(len_q);
    if (eff_len == 0 || eff_len > MAX_LEN)
      eff_len = MAX_LEN;
    last_ch = CW'((eff_len - 1) / LANES);
  end

  // One lane group: add each in-range product in turn, watching the carry out
  always_comb begin
    run_s    = acc_q;
    step_ovf = 1'b0;
    idx      = 0;
    prod     = '0;
    sum_t    = '0;
    for (int l = 0; l < LANES; l++) begin
      idx  = 32'(cnt_q) * LANES + l;
      prod = '0;
      if (idx < eff_len)
        prod = PW'(a_mem[EW'(idx)]) * PW'(b_mem[EW'(idx)]);
      sum_t = {1'b0, run_s} + (ACC_W+1)'(prod);
      step_ovf = step_ovf | sum_t[ACC_W];
`ifdef DOT_PRODUCT_SATURATE_EN
      if (sum_t[ACC_W])
        run_s = '1;
      else
        run_s = sum_t[ACC_W-1:0];
`else
      run_s = sum_t[ACC_W-1:0];
`endif
    end
    acc_nxt = run_s;
  end

  // Read mux over the word map; unmapped addresses read as zero
  always_comb begin
    rd_word = '0;
    if (addr_i == 0)
      rd_word = len_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (addr_i == 1 + i)
        rd_word = a_mem[i];
      if (addr_i == B_BASE + i)
        rd_word = b_mem[i];
    end
    for (int w = 0; w < RES_WORDS; w++) begin
      if (addr_i == R_BASE + w)
        rd_word = result_q[w*WORD_W +: WORD_W];
    end
  end

  // Vector store writes; contents survive reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (addr_i == 1 + i)
          a_mem[i] <= cmd_wdata;
        if (addr_i == B_BASE + i)
          b_mem[i] <= cmd_wdata;
      end
    end
  end

  // Command handling and the IDLE/MAC sequencer with registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
      result_q <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            do_rd: begin
              rd_data  <= rd_word;
              rd_valid <= 1'b1;
            end
            do_wr: begin
              if (addr_i == 0)
                len_q <= cmd_wdata;
            end
            do_run: begin
              acc_q <= run_accum ? result_q : '0;
              cnt_q <= '0;
              busy  <= 1'b1;
              state <= MAC;
            end
            do_clr: begin
              result_q <= '0;
              overflow <= 1'b0;
            end
            default: ;
          endcase
        end
        MAC: begin
          acc_q    <= acc_nxt;
          overflow <= overflow | step_ovf;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == last_ch) begin
            result_q <= acc_nxt;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed scenarios on a 16-bit and an 8-bit result build.
// Both instances see the same command stream; the 8-bit one exposes overflow.
module tb_dot_product_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [5:0] cmd_addr;
  logic [3:0] cmd_wdata;
  logic       run_accum;

  logic       cmd_ready, cmd_ready8;
  logic [3:0] rd_data, rd_data8;
  logic       rd_valid, rd_valid8;
  logic       busy, busy8;
  logic       done, done8;
  logic       overflow, overflow8;

  int cmp = 0;
  int err = 0;

  logic [3:0] d, d8;

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam logic [7:0] EXP8 = 8'hFF;
`else
  localparam logic [7:0] EXP8 = 8'h10;
`endif

  always #5 clk = ~clk;

  dot_product_engine #(
    .WORD_W(4), .MAX_LEN(16), .LANES(4), .ACC_W(16), .ADDR_W(6)
  ) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .run_accum(run_accum), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .overflow(overflow)
  );

  dot_product_engine #(
    .WORD_W(4), .MAX_LEN(16), .LANES(4), .ACC_W(8), .ADDR_W(6)
  ) u_dut8 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .run_accum(run_accum), .rd_data(rd_data8), .rd_valid(rd_valid8),
    .busy(busy8), .done(done8), .overflow(overflow8)
  );

  // Present a command at a falling edge, hold until accepted, return #1 after the accept edge
  task automatic issue(input logic [1:0] op, input logic [5:0] a,
                       input logic [3:0] wd, input logic acc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    run_accum = acc;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      cmp++; err++;
      $display("FAIL issue_timeout got ready=%0b want 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] wd);
    issue(2'd1, a, wd, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a, output logic [3:0] q, output logic [3:0] q8);
    issue(2'd0, a, 4'd0, 1'b0);
    q  = rd_data;
    q8 = rd_data8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got %0b want 0", busy); end
    cmp++; if (done !== 1'b0) begin err++; $display("FAIL rst_done got %0b want 0", done); end
    cmp++; if (rd_valid !== 1'b0) begin err++; $display("FAIL rst_rdv got %0b want 0", rd_valid); end
    cmp++; if (rd_data !== 4'h0) begin err++; $display("FAIL rst_rdd got %h want 0", rd_data); end
    cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL rst_ovf got %0b want 0", overflow); end
    cmp++; if (cmd_ready !== 1'b1) begin err++; $display("FAIL rst_rdy got %0b want 1", cmd_ready); end
    rst = 1'b0;
    rd(6'd0, d, d8);
    cmp++; if (rd_valid !== 1'b1) begin err++; $display("FAIL rst_rdv1 got %0b want 1", rd_valid); end
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL rst_len got %h want 0", d); end
    rd(6'd33, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL rst_res0 got %h want 0", d); end
    wr(6'd50, 4'h5);
    rd(6'd50, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL unmapped got %h want 0", d); end
    @(posedge clk); #1;
    cmp++; if (rd_valid !== 1'b0) begin err++; $display("FAIL rdv_pulse got %0b want 0", rd_valid); end
  endtask

  task automatic test_basic;
    wr(6'd0, 4'd3);
    wr(6'd1, 4'd1); wr(6'd2, 4'd2); wr(6'd3, 4'd3);
    wr(6'd17, 4'd4); wr(6'd18, 4'd5); wr(6'd19, 4'd6);
    issue(2'd2, 6'd0, 4'd0, 1'b0);
    cmp++; if (busy !== 1'b1 || done !== 1'b0) begin err++; $display("FAIL s1_t1 got busy=%0b done=%0b want 1/0", busy, done); end
    cmp++; if (cmd_ready !== 1'b0) begin err++; $display("FAIL s1_rdy got %0b want 0", cmd_ready); end
    @(posedge clk); #1;
    cmp++; if (busy !== 1'b0 || done !== 1'b1) begin err++; $display("FAIL s1_t2 got busy=%0b done=%0b want 0/1", busy, done); end
    @(posedge clk); #1;
    cmp++; if (done !== 1'b0) begin err++; $display("FAIL s1_donepulse got %0b want 0", done); end
    rd(6'd33, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s1_w0 got %h want 0", d); end
    rd(6'd34, d, d8);
    cmp++; if (d !== 4'h2) begin err++; $display("FAIL s1_w1 got %h want 2", d); end
    cmp++; if (d8 !== 4'h2) begin err++; $display("FAIL s1_w1_8 got %h want 2", d8); end
    rd(6'd35, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s1_w2 got %h want 0", d); end
    rd(6'd36, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s1_w3 got %h want 0", d); end
    cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL s1_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_accum;
    int n;
    issue(2'd2, 6'd0, 4'd0, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    cmp++; if (done !== 1'b1) begin err++; $display("FAIL s3_done got %0b want 1", done); end
    rd(6'd33, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s3_w0 got %h want 0", d); end
    rd(6'd34, d, d8);
    cmp++; if (d !== 4'h4) begin err++; $display("FAIL s3_w1 got %h want 4", d); end
    issue(2'd3, 6'd0, 4'd0, 1'b0);
    rd(6'd34, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL clr_w1 got %h want 0", d); end
    cmp++; if (d8 !== 4'h0) begin err++; $display("FAIL clr_w1_8 got %h want 0", d8); end
  endtask

  task automatic test_full_len;
    logic bad;
    wr(6'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      wr(6'(1 + i), 4'hF);
      wr(6'(17 + i), 4'hF);
    end
    issue(2'd2, 6'd0, 4'd0, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    cmp++; if (bad) begin err++; $display("FAIL s2_busy got a non-busy MAC cycle want busy T+1..T+4"); end
    cmp++; if (busy !== 1'b0 || done !== 1'b1) begin err++; $display("FAIL s2_t5 got busy=%0b done=%0b want 0/1", busy, done); end
    rd(6'd33, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s2_w0 got %h want 0", d); end
    cmp++; if (d8 !== EXP8[3:0]) begin err++; $display("FAIL s4_w0 got %h want %h", d8, EXP8[3:0]); end
    rd(6'd34, d, d8);
    cmp++; if (d !== 4'h1) begin err++; $display("FAIL s2_w1 got %h want 1", d); end
    cmp++; if (d8 !== EXP8[7:4]) begin err++; $display("FAIL s4_w1 got %h want %h", d8, EXP8[7:4]); end
    rd(6'd35, d, d8);
    cmp++; if (d !== 4'hE) begin err++; $display("FAIL s2_w2 got %h want e", d); end
    rd(6'd36, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s2_w3 got %h want 0", d); end
    cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL s2_ovf got %0b want 0", overflow); end
    cmp++; if (overflow8 !== 1'b1) begin err++; $display("FAIL s4_ovf got %0b want 1", overflow8); end
  endtask

  task automatic test_back_to_back;
    wr(6'd0, 4'd8);
    wr(6'd5, 4'd9);
    issue(2'd2, 6'd0, 4'd0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_addr  = 6'd5;
    cmp++; if (cmd_ready !== 1'b0) begin err++; $display("FAIL s5_hold1 got %0b want 0", cmd_ready); end
    @(posedge clk); #1;
    cmp++; if (cmd_ready !== 1'b0 || rd_valid !== 1'b0) begin err++; $display("FAIL s5_hold2 got rdy=%0b rdv=%0b want 0/0", cmd_ready, rd_valid); end
    @(posedge clk); #1;
    cmp++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin err++; $display("FAIL s5_done got done=%0b rdy=%0b want 1/1", done, cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmp++; if (rd_valid !== 1'b1 || rd_data !== 4'h9) begin err++; $display("FAIL s5_read got v=%0b d=%h want 1/9", rd_valid, rd_data); end
    @(posedge clk); #1;
    cmp++; if (rd_valid !== 1'b0) begin err++; $display("FAIL s5_rdv got %0b want 0", rd_valid); end
    wr(6'd33, 4'h7);
    rd(6'd33, d, d8);
    cmp++; if (d !== 4'hE) begin err++; $display("FAIL s5_ro got %h want e", d); end
    rd(6'd34, d, d8);
    cmp++; if (d !== 4'hA) begin err++; $display("FAIL s5_w1 got %h want a", d); end
    rd(6'd35, d, d8);
    cmp++; if (d !== 4'h6) begin err++; $display("FAIL s5_w2 got %h want 6", d); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    wr(6'd0, 4'd0);
    issue(2'd2, 6'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp++; if (busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL s6_abort got busy=%0b done=%0b want 0/0", busy, done); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    cmp++; if (seen) begin err++; $display("FAIL s6_nodone got a done pulse want none"); end
    rd(6'd0, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s6_len got %h want 0", d); end
    rd(6'd34, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s6_res got %h want 0", d); end
    rd(6'd35, d, d8);
    cmp++; if (d !== 4'h0) begin err++; $display("FAIL s6_res2 got %h want 0", d); end
    rd(6'd1, d, d8);
    cmp++; if (d !== 4'hF) begin err++; $display("FAIL s6_a0 got %h want f", d); end
    rd(6'd5, d, d8);
    cmp++; if (d !== 4'h9) begin err++; $display("FAIL s6_a4 got %h want 9", d); end
    rd(6'd24, d, d8);
    cmp++; if (d !== 4'hF) begin err++; $display("FAIL s6_b7 got %h want f", d); end
    cmp++; if (overflow8 !== 1'b0) begin err++; $display("FAIL s6_ovf8 got %0b want 0", overflow8); end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 6'd0;
    cmd_wdata = 4'd0;
    run_accum = 1'b0;
    test_reset();
    test_basic();
    test_accum();
    test_full_len();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
